// File: rtl/dff_response_checker.sv
// dff_response_checker
//
// Reading end of a flip-flop stimulus path. It keeps a LATENCY-deep history
// of the stimulus bit and compares the DUT output against the bit sampled
// LATENCY edges earlier. Each run performs CHECK_CYCLES comparisons and
// reports an error count, a sticky error flag and a pass/fail verdict.
//
// Parameters
//   LATENCY      edges between a d_in sample and its matching q_in (1..8)
//   CHECK_CYCLES comparisons per run (1 .. 2**CNT_W-1)
//   CNT_W        counter width
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous, active-high reset
//   en           run request: high starts/continues a run, low aborts/releases
//   d_in         stimulus bit driven into the DUT
//   q_in         DUT output
//   busy         high while warming up or checking
//   done         high once the run has finished all comparisons
//   pass         done with zero mismatches
//   err_flag     sticky, set by the first mismatch of a run
//   err_count    mismatches this run, saturating
//   cmp_count    comparisons performed this run
//
// Optional feature, enabled by defining DFF_CHECKER_FIRST_ERR_EN:
//   first_err_idx  0-based index of the first mismatching comparison
//   first_err_q    q_in value seen at that comparison

module dff_response_checker #(
    parameter int LATENCY      = 1,
    parameter int CHECK_CYCLES = 200,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             d_in,
    input  logic             q_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_flag,
    output logic [CNT_W-1:0] err_count,
`ifdef DFF_CHECKER_FIRST_ERR_EN
    output logic [CNT_W-1:0] cmp_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic             first_err_q
`else
    output logic [CNT_W-1:0] cmp_count
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WARMUP = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [3:0]       WARM_INIT = 4'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CMP_LAST  = CNT_W'(CHECK_CYCLES - 1);
    localparam logic [CNT_W-1:0] ERR_MAX   = '1;

    logic [1:0]         state_q,    state_d;
    logic [LATENCY-1:0] hist_q,     hist_d;
    logic [3:0]         warm_q,     warm_d;
    logic [CNT_W-1:0]   errCount_q, errCount_d;
    logic [CNT_W-1:0]   cmpCount_q, cmpCount_d;
    logic               errFlag_q,  errFlag_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic               pass_q,     pass_d;
    logic               mismatch;
`ifdef DFF_CHECKER_FIRST_ERR_EN
    logic [CNT_W-1:0]   firstIdx_q, firstIdx_d;
    logic               firstQ_q,   firstQ_d;
`endif

    // The history shifts on every edge regardless of state, so that by the
    // time warm-up ends the oldest stage holds a bit sampled inside this run.
    always_comb begin
        hist_d    = hist_q;
        hist_d[0] = d_in;
        for (int i = 1; i < LATENCY; i++) begin
            hist_d[i] = hist_q[i-1];
        end
    end

    // The oldest history stage is the bit the DUT should be presenting now.
    assign mismatch = (q_in != hist_q[LATENCY-1]);

    // Run sequencing and result accumulation. Dropping en while busy returns
    // to IDLE without comparing on that edge and leaves partial results
    // readable; results only clear when the next run starts.
    always_comb begin
        state_d    = state_q;
        warm_d     = warm_q;
        errCount_d = errCount_q;
        cmpCount_d = cmpCount_q;
        errFlag_d  = errFlag_q;
`ifdef DFF_CHECKER_FIRST_ERR_EN
        firstIdx_d = firstIdx_q;
        firstQ_d   = firstQ_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d    = ST_WARMUP;
                    warm_d     = WARM_INIT;
                    errCount_d = '0;
                    cmpCount_d = '0;
                    errFlag_d  = 1'b0;
`ifdef DFF_CHECKER_FIRST_ERR_EN
                    firstIdx_d = '0;
                    firstQ_d   = 1'b0;
`endif
                end
            end
            ST_WARMUP: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (warm_q == 4'd0) begin
                    state_d = ST_CHECK;
                end else begin
                    warm_d = warm_q - 4'd1;
                end
            end
            ST_CHECK: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else begin
                    cmpCount_d = cmpCount_q + 1'b1;
                    if (mismatch) begin
                        errFlag_d = 1'b1;
                        if (errCount_q != ERR_MAX) begin
                            errCount_d = errCount_q + 1'b1;
                        end
`ifdef DFF_CHECKER_FIRST_ERR_EN
                        if (!errFlag_q) begin
                            firstIdx_d = cmpCount_q;
                            firstQ_d   = q_in;
                        end
`endif
                    end
                    if (cmpCount_q == CMP_LAST) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_WARMUP) || (state_d == ST_CHECK);
        done_d = (state_d == ST_DONE);
        pass_d = done_d && (errCount_d == '0);
    end

    // Status outputs are registered from next-state decode so every output
    // changes only on a clock edge (or on reset).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hist_q     <= '0;
            warm_q     <= '0;
            errCount_q <= '0;
            cmpCount_q <= '0;
            errFlag_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
`ifdef DFF_CHECKER_FIRST_ERR_EN
            firstIdx_q <= '0;
            firstQ_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            hist_q     <= hist_d;
            warm_q     <= warm_d;
            errCount_q <= errCount_d;
            cmpCount_q <= cmpCount_d;
            errFlag_q  <= errFlag_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
`ifdef DFF_CHECKER_FIRST_ERR_EN
            firstIdx_q <= firstIdx_d;
            firstQ_q   <= firstQ_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_flag  = errFlag_q;
    assign err_count = errCount_q;
    assign cmp_count = cmpCount_q;
`ifdef DFF_CHECKER_FIRST_ERR_EN
    assign first_err_idx = firstIdx_q;
    assign first_err_q   = firstQ_q;
`endif

endmodule

// File: tb/tb_dff_response_checker.sv
// tb_dff_response_checker
//
// Two checker instances share clk/rst:
//   dut0: LATENCY=1, CHECK_CYCLES=200, CNT_W=16
//   dut1: LATENCY=3, CHECK_CYCLES=15,  CNT_W=4
// The bench plays the part of the flip-flop DUT feeding q_in (a pipeline of
// configurable depth with optional forced inversions) and predicts every
// checker output from the run's enabling edge, the edge en was dropped and
// logs of every d/q value applied, using the checker's timing rules.
// Define DFF_CHECKER_FIRST_ERR_EN to also check the first-error outputs.

module tb_dff_response_checker;

    localparam int INF = 1 << 30;
    localparam int LOGN = 4096;

    int latP[2] = '{1, 3};
    int nP[2]   = '{200, 15};
    int wP[2]   = '{16, 4};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enV[2];
    logic dV[2];
    logic qV[2];

    logic        busyO[2];
    logic        doneO[2];
    logic        passO[2];
    logic        flagO[2];
    logic [15:0] errO[2];
    logic [15:0] cmpO[2];
    logic [3:0]  err1;
    logic [3:0]  cmp1;
`ifdef DFF_CHECKER_FIRST_ERR_EN
    logic [15:0] fIdxO[2];
    logic [3:0]  fIdx1;
    logic        fQO[2];
`endif

    // Bench-side DUT model and run bookkeeping
    bit dLog[2][0:LOGN-1];
    bit qLog[2][0:LOGN-1];
    int dlyP[2];
    int invLo[2];
    int invHi[2];
    int e0[2];
    int runEnd[2];
    bit enCmd[2];
    bit dCmd[2];
    int eNow;

    int passCnt;
    int totalCnt;

    always #5 clk = ~clk;

    dff_response_checker #(.LATENCY(1), .CHECK_CYCLES(200), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .en(enV[0]), .d_in(dV[0]), .q_in(qV[0]),
        .busy(busyO[0]), .done(doneO[0]), .pass(passO[0]), .err_flag(flagO[0]),
        .err_count(errO[0]),
`ifdef DFF_CHECKER_FIRST_ERR_EN
        .first_err_idx(fIdxO[0]), .first_err_q(fQO[0]),
`endif
        .cmp_count(cmpO[0])
    );

    dff_response_checker #(.LATENCY(3), .CHECK_CYCLES(15), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .en(enV[1]), .d_in(dV[1]), .q_in(qV[1]),
        .busy(busyO[1]), .done(doneO[1]), .pass(passO[1]), .err_flag(flagO[1]),
        .err_count(err1),
`ifdef DFF_CHECKER_FIRST_ERR_EN
        .first_err_idx(fIdx1), .first_err_q(fQO[1]),
`endif
        .cmp_count(cmp1)
    );

    assign errO[1] = 16'(err1);
    assign cmpO[1] = 16'(cmp1);
`ifdef DFF_CHECKER_FIRST_ERR_EN
    assign fIdxO[1] = 16'(fIdx1);
`endif

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Predict and check all outputs of instance i after the latest edge
    task automatic checkOutput(input int i);
        int eff, cmp, raw, fIdx, ce, lat, n, maxErr;
        bit fQ, busyE, doneE;
        string pfx;
        lat = latP[i];
        n = nP[i];
        maxErr = (1 << wP[i]) - 1;
        cmp = 0; raw = 0; fIdx = -1; fQ = 1'b0; busyE = 1'b0; doneE = 1'b0;
        if (e0[i] >= 0) begin
            eff = (runEnd[i] == INF) ? eNow : runEnd[i] - 1;
            cmp = eff - e0[i] - lat;
            if (cmp < 0) cmp = 0;
            if (cmp > n) cmp = n;
            for (int j = 0; j < cmp; j++) begin
                ce = e0[i] + lat + 1 + j;
                if (qLog[i][ce] != dLog[i][ce-lat]) begin
                    raw++;
                    if (fIdx < 0) begin
                        fIdx = j;
                        fQ = qLog[i][ce];
                    end
                end
            end
            busyE = (eNow < runEnd[i]) && (eNow - e0[i] < lat + n);
            doneE = (eNow < runEnd[i]) && (eNow - e0[i] >= lat + n);
        end
        pfx = $sformatf("dut%0d e%0d", i, eNow);
        checkVal({pfx, " busy"}, 32'(busyO[i]), 32'(busyE));
        checkVal({pfx, " done"}, 32'(doneO[i]), 32'(doneE));
        checkVal({pfx, " pass"}, 32'(passO[i]), 32'(doneE && raw == 0));
        checkVal({pfx, " err_flag"}, 32'(flagO[i]), 32'(raw > 0));
        checkVal({pfx, " err_count"}, 32'(errO[i]), 32'((raw > maxErr) ? maxErr : raw));
        checkVal({pfx, " cmp_count"}, 32'(cmpO[i]), 32'(cmp));
`ifdef DFF_CHECKER_FIRST_ERR_EN
        checkVal({pfx, " first_err_idx"}, 32'(fIdxO[i]), 32'((fIdx < 0) ? 0 : fIdx));
        checkVal({pfx, " first_err_q"}, 32'(fQO[i]), 32'(fQ));
`endif
    endtask

    // Drive one cycle of stimulus into both checkers, clock it, update the
    // run bookkeeping from the en value sampled, then check both instances
    task automatic applyStimulus();
        int eNext, j;
        bit qv;
        eNext = eNow + 1;
        for (int i = 0; i < 2; i++) begin
            dLog[i][eNext] = dCmd[i];
            qv = (eNext - dlyP[i] >= 0) ? dLog[i][eNext-dlyP[i]] : 1'b0;
            if (e0[i] >= 0 && runEnd[i] == INF) begin
                j = eNext - e0[i] - latP[i] - 1;
                if (j >= invLo[i] && j <= invHi[i]) qv = ~qv;
            end
            qLog[i][eNext] = qv;
            enV[i] = enCmd[i];
            dV[i] = dCmd[i];
            qV[i] = qv;
        end
        @(posedge clk);
        eNow++;
        for (int i = 0; i < 2; i++) begin
            if (e0[i] < 0 || runEnd[i] != INF) begin
                if (enCmd[i]) begin
                    e0[i] = eNow;
                    runEnd[i] = INF;
                end
            end else if (!enCmd[i]) begin
                runEnd[i] = eNow;
            end
        end
        #1;
        checkOutput(0);
        checkOutput(1);
    endtask

    task automatic runCycles(input int count, input bit en0, input bit en1, input int dMode0, input int dMode1);
        for (int k = 0; k < count; k++) begin
            enCmd[0] = en0;
            enCmd[1] = en1;
            dCmd[0] = (dMode0 == 1) ? 1'((eNow / 6) % 2) : (dMode0 == 2) ? 1'(eNow % 2) : 1'($urandom_range(0, 1));
            dCmd[1] = (dMode1 == 1) ? 1'((eNow / 6) % 2) : (dMode1 == 2) ? 1'(eNow % 2) : 1'($urandom_range(0, 1));
            applyStimulus();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        passCnt = 0;
        totalCnt = 0;
        eNow = 0;
        for (int i = 0; i < 2; i++) begin
            enV[i] = 1'b0; dV[i] = 1'b0; qV[i] = 1'b0;
            enCmd[i] = 1'b0; dCmd[i] = 1'b0;
            e0[i] = -1; runEnd[i] = INF;
            dlyP[i] = latP[i];
            invLo[i] = -1; invHi[i] = -2;
        end

        // Reset state while reset is held
        #2;
        checkOutput(0);
        checkOutput(1);
        #5 rst = 1'b0;

        // dut0: ideal flip-flop, d toggling every 6 cycles, en held past done
        runCycles(206, 1'b1, 1'b0, 1, 0);
        runCycles(2, 1'b0, 1'b0, 0, 0);

        // dut0: q forced inverted for compare indices 10..12
        invLo[0] = 10; invHi[0] = 12;
        runCycles(205, 1'b1, 1'b0, 0, 0);
        runCycles(2, 1'b0, 1'b0, 0, 0);
        invLo[0] = -1; invHi[0] = -2;

        // dut0: abort after 50 compares, hold partial results, then full run
        runCycles(52, 1'b1, 1'b0, 0, 0);
        runCycles(4, 1'b0, 1'b0, 0, 0);
        runCycles(205, 1'b1, 1'b0, 0, 0);
        runCycles(2, 1'b0, 1'b0, 0, 0);

        // dut1: matching 3-stage pipeline passes
        runCycles(21, 1'b0, 1'b1, 0, 0);
        runCycles(2, 1'b0, 1'b0, 0, 0);

        // dut1: abort during warm-up
        runCycles(2, 1'b0, 1'b1, 0, 0);
        runCycles(2, 1'b0, 1'b0, 0, 0);

        // dut1: 2-stage pipeline against alternating d mismatches every compare
        dlyP[1] = 2;
        runCycles(21, 1'b0, 1'b1, 0, 2);
        runCycles(2, 1'b0, 1'b0, 0, 2);

        // dut1: asynchronous reset in the middle of CHECK
        runCycles(10, 1'b0, 1'b1, 0, 2);
        #2 rst = 1'b1;
        #1;
        e0[0] = -1; runEnd[0] = INF;
        e0[1] = -1; runEnd[1] = INF;
        checkOutput(0);
        checkOutput(1);
        #2 rst = 1'b0;

        // dut1: en still high restarts from IDLE with a matching pipeline
        dlyP[1] = 3;
        runCycles(20, 1'b0, 1'b1, 0, 0);
        runCycles(2, 1'b0, 1'b0, 0, 0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
